// File: rtl/envelope_gen.sv
// Per-voice ADSR envelope that scales one signed sample per frame tick and
// emits it with a one-cycle valid strobe. Define ENV_EXP_RELEASE_EN for exponential release.
module envelope_gen #(
  parameter int SAMPLE_W      = 16,
  parameter int ENV_W         = 16,
  parameter int RELEASE_SHIFT = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  input  logic                       gate,
  input  logic [ENV_W-1:0]           attack_rate,
  input  logic [ENV_W-1:0]           decay_rate,
  input  logic [ENV_W-1:0]           sustain_level,
  input  logic [ENV_W-1:0]           release_rate,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic [ENV_W-1:0]           env_level,
  output logic [2:0]                 env_state,
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam int                PROD_W    = SAMPLE_W + ENV_W + 1;
  localparam logic [ENV_W-1:0]  LEVEL_MAX = '1;

  state_t                    state;
  logic                      gate_q;
  logic                      rise, fall;
  logic [ENV_W:0]            attack_sum;
  logic                      attack_full;
  logic                      decay_done;
  logic [ENV_W:0]            rel_step;
  logic                      release_done;
  logic [ENV_W-1:0]          release_next;
  logic signed [PROD_W-1:0]  prod;
  logic                      prod_vld;

  assign env_state = state;
  assign busy      = (state != S_IDLE);

  // Every step result is computed one bit wider so the level never wraps.
  always_comb begin
    rise        = gate & ~gate_q;
    fall        = ~gate & gate_q;
    attack_sum  = {1'b0, env_level} + {1'b0, attack_rate};
    attack_full = (attack_sum >= {1'b0, LEVEL_MAX});
    decay_done  = ({1'b0, env_level} <= ({1'b0, sustain_level} + {1'b0, decay_rate}));
`ifdef ENV_EXP_RELEASE_EN
    rel_step    = ({1'b0, env_level} >> RELEASE_SHIFT) + (ENV_W+1)'(1);
`else
    rel_step    = {1'b0, release_rate};
`endif
    release_done = ({1'b0, env_level} <= rel_step);
    release_next = env_level - rel_step[ENV_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      env_level <= '0;
      gate_q    <= 1'b0;
    end else if (sample_tick) begin
      gate_q <= gate;
      if (rise) begin
        state <= S_ATTACK;
      end else if (fall && (state == S_ATTACK || state == S_DECAY || state == S_SUSTAIN)) begin
        state <= S_RELEASE;
      end else begin
        unique case (state)
          S_IDLE: env_level <= '0;
          S_ATTACK: begin
            if (attack_full) begin
              env_level <= LEVEL_MAX;
              state     <= S_DECAY;
            end else begin
              env_level <= attack_sum[ENV_W-1:0];
            end
          end
          S_DECAY: begin
            if (decay_done) begin
              env_level <= sustain_level;
              state     <= S_SUSTAIN;
            end else begin
              env_level <= env_level - decay_rate;
            end
          end
          S_SUSTAIN: env_level <= sustain_level;
          S_RELEASE: begin
            if (release_done) begin
              env_level <= '0;
              state     <= S_IDLE;
            end else begin
              env_level <= release_next;
            end
          end
          default: begin
            env_level <= '0;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end

  // NOTE: the pipeline registers are reset too, so a reset mid-note can never
  // leak a stale product or valid pulse afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod         <= '0;
      prod_vld     <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (sample_tick)
        prod <= PROD_W'(sample_in) * PROD_W'($signed({1'b0, env_level}));
      prod_vld     <= sample_tick;
      sample_valid <= prod_vld;
      if (prod_vld)
        sample_out <= prod[SAMPLE_W+ENV_W-1:ENV_W];
    end
  end

endmodule

// File: tb/tb_envelope_gen.sv
// Randomised self-checking bench for envelope_gen against an integer ADSR model
// and a queue of expected scaled samples with their due cycle.
module tb_envelope_gen;

  localparam int RELEASE_SHIFT = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_tick;
  logic               gate;
  logic [15:0]        attack_rate, decay_rate, sustain_level, release_rate;
  logic signed [15:0] sample_in;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic [15:0]        env_level;
  logic [2:0]         env_state;
  logic               busy;

  envelope_gen #(.SAMPLE_W(16), .ENV_W(16), .RELEASE_SHIFT(RELEASE_SHIFT)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .sample_in(sample_in), .sample_out(sample_out), .sample_valid(sample_valid),
    .env_level(env_level), .env_state(env_state), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain integer ADSR plus expected-output queue.
  typedef struct { int value; int due; } exp_t;
  exp_t pend[$];
  exp_t head;
  int   m_state = 0;
  int   m_level = 0;
  bit   m_gate_q = 0;

  task automatic model_step(input bit g, input logic signed [15:0] s);
    longint p;
    bit rise, fall;
    int step;
    p = longint'(s) * longint'(m_level);
    pend.push_back('{value: int'((p >>> 16) & 64'hFFFF), due: cyc + 1});
    rise = g && !m_gate_q;
    fall = !g && m_gate_q;
    m_gate_q = g;
    if (rise) m_state = 1;
    else if (fall && m_state >= 1 && m_state <= 3) m_state = 4;
    else begin
      case (m_state)
        0: m_level = 0;
        1: if (m_level + int'(attack_rate) >= 65535) begin m_level = 65535; m_state = 2; end
           else m_level = m_level + int'(attack_rate);
        2: if (m_level - int'(decay_rate) <= int'(sustain_level)) begin
             m_level = int'(sustain_level); m_state = 3;
           end else m_level = m_level - int'(decay_rate);
        3: m_level = int'(sustain_level);
        default: begin
`ifdef ENV_EXP_RELEASE_EN
          step = (m_level >> RELEASE_SHIFT) + 1;
`else
          step = int'(release_rate);
`endif
          if (m_level - step <= 0) begin m_level = 0; m_state = 0; end
          else m_level = m_level - step;
        end
      endcase
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_level = 0; m_gate_q = 0;
    pend.delete();
  endtask

  task automatic do_tick(input bit g, input logic [15:0] s);
    @(negedge clk);
    gate = g; sample_in = s; sample_tick = 1'b1;
    @(posedge clk);
    #1;
    if (reset) model_step(g, s);
    check("env_state", env_state, m_state);
    check("env_level", env_level, m_level);
    check("busy", busy, m_state != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_tick = 1'b0;
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    sample_tick = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_state", env_state, 0);
    check("rst_level", env_level, 0);
    check("rst_out", $unsigned(sample_out), 0);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("valid_in_reset", sample_valid, 0);
    end else if (sample_valid) begin
      if (pend.size() == 0) begin
        check("valid_spurious", 1, 0);
      end else begin
        head = pend.pop_front();
        check("valid_latency", cyc, head.due);
        check("sample_out", $unsigned(sample_out), head.value);
      end
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      check("valid_missing", 0, 1);
      void'(pend.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; sample_tick = 1'b0; gate = 1'b0; sample_in = '0;
    attack_rate = 16'h4000; decay_rate = 16'h1000;
    sustain_level = 16'hC000; release_rate = 16'h3000;
    repeat (2) @(negedge clk);
    check("init_state", env_state, 0);
    check("init_level", env_level, 0);
    check("init_out", $unsigned(sample_out), 0);

    // Ticks under reset do nothing.
    for (int i = 0; i < 3; i++) do_tick(1'b1, 16'h7FFF);
    idle(3);
    reset = 1'b1;
    idle(1);

    // Attack, decay, sustain change.
    do_tick(1'b1, 16'h0000);
    check("plan_attack_state", env_state, 1);
    do_tick(1'b1, 16'h1234);
    do_tick(1'b1, 16'h0100);
    do_tick(1'b1, 16'h4000);            // pre-level 0x8000 -> 0x2000
    do_tick(1'b1, 16'h8000);
    check("plan_attack_peak", env_level, 16'hFFFF);
    do_tick(1'b1, 16'h4000);            // pre-level 0xFFFF -> 0x3FFF
    idle(2);
    for (int i = 0; i < 4; i++) do_tick(1'b1, 16'h7FFF);
    check("plan_sustain_state", env_state, 3);
    sustain_level = 16'hA000;
    do_tick(1'b1, 16'hFFFF);
    check("plan_sustain_track", env_level, 16'hA000);

    // Release then retrigger from 0x7000.
    do_tick(1'b0, 16'h0001);
    do_tick(1'b0, 16'h8001);
    do_tick(1'b1, 16'h2000);
    check("plan_retrig_state", env_state, 1);
    do_tick(1'b1, 16'h2000);

    // Full linear release from 0xA000.
    decay_rate = 16'h6000;
    for (int i = 0; i < 4; i++) do_tick(1'b1, 16'h1111);
    for (int i = 0; i < 6; i++) do_tick(1'b0, 16'h5555);
    idle(3);

    // Negative sample at mid level: 0xC000 @ 0x8000 -> 0xE000.
    attack_rate = 16'h8000;
    do_tick(1'b1, 16'h0000);
    do_tick(1'b1, 16'h0000);
    do_tick(1'b1, 16'hC000);
    idle(1);
    async_reset();
    idle(2);

    // Randomised phase.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        attack_rate   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        decay_rate    = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h4000));
        sustain_level = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        release_rate  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h4000));
      end
      if ($urandom_range(0, 5) == 0) gate = ~gate;
      do_tick(gate, 16'($urandom));
      if ($urandom_range(0, 120) == 0) async_reset();
      else idle($urandom_range(0, 2));
    end

    idle(4);
    check("pend_drained", pend.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
